// File: rtl/secuenciador_movimiento.sv
`default_nettype none
// ============================================================================
// Module   : secuenciador_movimiento
// Purpose  : Timed motion-command sequencer feeding the H-bridge driver; holds
//            a movement code for a ms-exact duration, then enforces dead-time.
// Revision : 1.0 - initial release
// ============================================================================
module secuenciador_movimiento #(
   parameter int CLK_PER_MS = 100000,
   parameter int DUR_W      = 16,
   parameter int DEAD_MS    = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       cmd,
   input  logic [DUR_W-1:0] duracion,
   input  logic             abort,
   output logic [2:0]       movimiento,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             err,
   output logic [DUR_W-1:0] ms_restantes
);

   localparam int               PW        = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_PER_MS - 1);
   localparam logic [DUR_W-1:0] DEAD_LOAD = DUR_W'(DEAD_MS);
   localparam logic [DUR_W-1:0] MS_ONE    = DUR_W'(1);
   localparam logic [2:0]       MOV_P     = 3'd0;
   localparam logic [2:0]       CMD_MAX   = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DEAD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [DUR_W-1:0] ms_q, ms_d;
   logic [2:0]       mov_q, mov_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;
   logic             err_q, err_d;
   logic             supp_q, supp_d;
   logic             tick;

   assign tick = (presc_q == PRESC_MAX);

   always_comb begin
      state_d   = state_q;
      presc_d   = tick ? '0 : presc_q + 1'b1;
      ms_d      = ms_q;
      mov_d     = mov_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      err_d     = 1'b0;
      supp_d    = supp_q;

      case (state_q)
         S_IDLE: begin
            presc_d = '0;
            if (start) begin
               if (cmd > CMD_MAX) begin
                  err_d = 1'b1;
               end else if (duracion != '0) begin
                  state_d = S_RUN;
                  mov_d   = cmd;
                  ms_d    = duracion;
                  busy_d  = 1'b1;
                  supp_d  = 1'b0;
               end else begin
                  state_d = S_DEAD;
                  mov_d   = MOV_P;
                  ms_d    = DEAD_LOAD;
                  busy_d  = 1'b1;
                  supp_d  = 1'b0;
               end
            end
         end
         S_RUN: begin
            // Abort has priority over a coincident terminal tick.
            if (abort) begin
               state_d   = S_DEAD;
               presc_d   = '0;
               mov_d     = MOV_P;
               ms_d      = DEAD_LOAD;
               aborted_d = 1'b1;
               supp_d    = 1'b1;
            end else if (tick) begin
               if (ms_q == MS_ONE) begin
                  state_d = S_DEAD;
                  mov_d   = MOV_P;
                  ms_d    = DEAD_LOAD;
               end else begin
                  ms_d = ms_q - 1'b1;
               end
            end
         end
         S_DEAD: begin
            if (tick) begin
               if (ms_q == MS_ONE) begin
                  state_d = S_IDLE;
                  ms_d    = '0;
                  busy_d  = 1'b0;
                  done_d  = ~supp_q;
               end else begin
                  ms_d = ms_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            presc_d = '0;
            ms_d    = '0;
            mov_d   = MOV_P;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         presc_q   <= '0;
         ms_q      <= '0;
         mov_q     <= MOV_P;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         err_q     <= 1'b0;
         supp_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         ms_q      <= ms_d;
         mov_q     <= mov_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         err_q     <= err_d;
         supp_q    <= supp_d;
      end
   end

   assign movimiento   = mov_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign aborted      = aborted_q;
   assign err          = err_q;
   assign ms_restantes = ms_q;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_movimiento.sv
`default_nettype none
// ============================================================================
// Module   : tb_secuenciador_movimiento
// Purpose  : Self-checking bench; cycle-count reference model of the phases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_secuenciador_movimiento;

   localparam int CPM   = 10;
   localparam int DW    = 16;
   localparam int DMS   = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [2:0]    cmd;
   logic [DW-1:0] duracion;
   logic          abort;
   logic [2:0]    movimiento;
   logic          busy, done, aborted, err;
   logic [DW-1:0] ms_restantes;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: phase 0=idle 1=run 2=dead, cycles left in phase, held code.
   int m_phase, m_left, m_code;
   bit m_supp, m_done, m_abt, m_err;

   secuenciador_movimiento #(
      .CLK_PER_MS (CPM),
      .DUR_W      (DW),
      .DEAD_MS    (DMS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cmd          (cmd),
      .duracion     (duracion),
      .abort        (abort),
      .movimiento   (movimiento),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .err          (err),
      .ms_restantes (ms_restantes)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_phase = 0; m_left = 0; m_code = 0;
      m_supp = 0; m_done = 0; m_abt = 0; m_err = 0;
   endtask

   task automatic model_update();
      m_done = 0; m_abt = 0; m_err = 0;
      if (!rst_n) begin
         model_reset();
      end else if (m_phase == 1) begin
         if (abort) begin
            m_phase = 2; m_left = DMS * CPM; m_code = 0; m_abt = 1; m_supp = 1;
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_phase = 2; m_left = DMS * CPM; m_code = 0;
            end
         end
      end else if (m_phase == 2) begin
         m_left--;
         if (m_left == 0) begin
            m_phase = 0; m_done = !m_supp;
         end
      end else if (start) begin
         if (cmd > 3'd4) begin
            m_err = 1;
         end else if (duracion != 0) begin
            m_phase = 1; m_left = int'(duracion) * CPM; m_code = int'(cmd); m_supp = 0;
         end else begin
            m_phase = 2; m_left = DMS * CPM; m_code = 0; m_supp = 0;
         end
      end
   endtask

   task automatic check_all();
      int exp_ms;
      exp_ms = (m_phase == 0) ? 0 : (m_left + CPM - 1) / CPM;
      check("movimiento", 32'(movimiento), 32'(m_code));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("done", 32'(done), 32'(m_done));
      check("aborted", 32'(aborted), 32'(m_abt));
      check("err", 32'(err), 32'(m_err));
      check("ms_restantes", 32'(ms_restantes), 32'(exp_ms));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic issue(input logic [2:0] c, input int d);
      start = 1'b1; cmd = c; duracion = DW'(d);
      cycle();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cmd = '0; duracion = '0; abort = 1'b0;
      model_reset();
      run(2);
      rst_n = 1'b1;
      run(3);

      // Normal run, then dead-time and done
      issue(3'd1, 3);
      run(55);

      // Abort on RUN cycle 12
      issue(3'd3, 5);
      run(11);
      abort = 1'b1; cycle(); abort = 1'b0;
      run(25);

      // Invalid command, then start while busy
      issue(3'd6, 4);
      run(2);
      issue(3'd1, 2);
      run(4);
      issue(3'd2, 3);
      run(40);

      // Zero duration; next start in the done cycle
      issue(3'd4, 0);
      for (int i = 0; i < 40 && !m_done; i++) cycle();
      check("done_seen_zero_dur", 32'(done), 32'd1);
      issue(3'd2, 2);
      run(45);

      // Reset mid-run is asynchronous
      issue(3'd1, 5);
      run(15);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_mov", 32'(movimiento), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_ms", 32'(ms_restantes), 32'd0);
      run(3);
      rst_n = 1'b1;
      run(2);
      issue(3'd3, 1);
      run(35);

      // Abort coincident with final RUN tick
      issue(3'd2, 2);
      run(19);
      abort = 1'b1; cycle(); abort = 1'b0;
      run(25);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start    = ($urandom_range(0, 7) == 0);
         cmd      = 3'($urandom_range(0, 7));
         duracion = DW'($urandom_range(0, 4));
         abort    = ($urandom_range(0, 39) == 0);
         cycle();
      end
      start = 1'b0; abort = 1'b0;
      run(80);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/secuenciador_movimiento.md
Name: secuenciador_movimiento

Overview:
- Timed motion-command sequencer. Sits directly upstream of the H-bridge motor driver and produces its 3-bit movement code.
- The CPU (via a CSR wrapper) issues a movement code plus a duration in milliseconds. The block holds that code for exactly the requested time, then forces a pause dead-time before accepting the next command.
- The dead-time protects the L298 against direct direction reversals. The block also reports busy/done/abort/error status.

Parameters:
- CLK_PER_MS, 100000, clock cycles per 1 ms tick (100 MHz system clock).
- DUR_W, 16, width of the duration field in ms.
- DEAD_MS, 20, mandatory pause (ms) after every run or abort; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe, sampled only in IDLE.
- cmd  in  3  movement code: 0=P, 1=A, 2=R, 3=GD, 4=GI; 5..7 invalid.
- duracion  in  DUR_W  run time in ms, sampled with start.
- abort  in  1  level/pulse; terminates the current run.
- movimiento  out  3  movement code to the motor driver, registered.
- busy  out  1  high in RUN and DEAD.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when abort takes effect.
- err  out  1  one-cycle pulse when start carries an invalid cmd.
- ms_restantes  out  DUR_W  ms left in the current phase (RUN or DEAD); 0 in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, movimiento=0 (P), busy=0, done=0, aborted=0, err=0, ms_restantes=0, prescaler=0. Takes effect immediately, including mid-RUN: motors go to P without dead-time.
- States: IDLE, RUN, DEAD.
- Prescaler: counts 0..CLK_PER_MS-1 and emits tick when it equals CLK_PER_MS-1. It is cleared on every state entry, so phases are cycle-exact.
- IDLE, start=1, cmd<=4, duracion>0:
  - Next cycle: state=RUN, movimiento=cmd, busy=1, ms_restantes=duracion.
- IDLE, start=1, cmd<=4, duracion=0:
  - Go directly to DEAD (movimiento=P); done still pulses at the end of DEAD.
- IDLE, start=1, cmd>4:
  - err=1 for one cycle; stay in IDLE; nothing latched.
- IDLE, start=1, cmd=0 (P): valid; runs a timed pause followed by DEAD.
- RUN:
  - On each tick, ms_restantes decrements.
  - When a tick occurs with ms_restantes=1: next cycle state=DEAD, movimiento=P, ms_restantes=DEAD_MS.
  - movimiento therefore equals cmd for exactly duracion*CLK_PER_MS cycles.
- DEAD:
  - movimiento=P and busy=1.
  - Decrement on tick. When a tick occurs with ms_restantes=1: next cycle state=IDLE, busy=0, and done=1 for that single cycle.
  - DEAD lasts exactly DEAD_MS*CLK_PER_MS cycles.
- Abort:
  - abort=1 in RUN: next cycle state=DEAD, movimiento=P, ms_restantes=DEAD_MS, aborted=1 for one cycle. No done at the end of that DEAD.
  - abort in DEAD: ignored (the dead-time is never shortened).
  - abort in IDLE: ignored; no pulse.
- Simultaneous events:
  - abort and a terminal tick in the same RUN cycle: abort wins (aborted pulses, done suppressed).
  - start while busy: ignored; no err.
  - start in the same cycle done is high: accepted, since state is already IDLE.
- movimiento changes only on state transitions and never goes directly from one non-P code to another.
- ms_restantes is DUR_W wide with no wrap; DEAD_MS must fit in DUR_W.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
(Bench parameters: CLK_PER_MS=10, DEAD_MS=2.)
- Normal run: reset, start with cmd=1, duracion=3 → movimiento=1 for exactly 30 cycles starting 1 cycle after start; then movimiento=0 for 20 cycles with busy=1; then done=1 for one cycle and busy=0.
- Abort: start with cmd=3, duracion=5; assert abort on cycle 12 of RUN → movimiento=0 the next cycle, aborted=1 for one cycle, busy=1 for 20 more cycles, no done pulse.
- Invalid and busy starts: start with cmd=6 → err=1 for one cycle, movimiento stays 0, busy=0. Then start with cmd=2 during RUN → ignored, movimiento unchanged, no err.
- Zero duration and back-to-back: start with cmd=4, duracion=0 → movimiento never becomes 4; DEAD lasts 20 cycles, then done. Start with cmd=2 in the done cycle → accepted; movimiento=2 on the next cycle.
- Reset mid-run: rst_n low for 3 cycles during RUN with cmd=1 → movimiento=0 and busy=0 asynchronously, ms_restantes=0. After release the block is in IDLE and a new start works normally.
- Abort/tick collision: abort coincident with the final RUN tick → aborted=1, done never pulses, DEAD lasts 20 cycles.
